// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display drivers.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Upper bound on the number of digits one scan driver may multiplex.
  localparam int MAX_DIGITS = 8;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ERR   = 7'b0101010;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between a controller and the seg7_scan_driver.
// Optional decimal-point signals exist only when SEG7_DECIMAL_POINT_EN is defined.
//
// Handshake: there is no valid/ready pair. load is a single-cycle strobe that
// is always accepted; the value on bcd_in (and dp_in) in that cycle is captured
// and shown from the next frame boundary on. frame_done is a one-cycle
// notification with no back-pressure.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg7;
  logic                    frame_done;

`ifdef SEG7_DECIMAL_POINT_EN
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    dp;

  modport master (
    output bcd_in, load, blank, dp_in,
    input  an, seg7, frame_done, dp
  );

  modport slave (
    input  bcd_in, load, blank, dp_in,
    output an, seg7, frame_done, dp
  );
`else
  modport master (
    output bcd_in, load, blank,
    input  an, seg7, frame_done
  );

  modport slave (
    input  bcd_in, load, blank,
    output an, seg7, frame_done
  );
`endif

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to common-anode 7-segment decoder.
// Non-decimal inputs (10..15) show the error pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup from nibble to active-low segment code.
  always_comb begin
    seg = SEG_ERR;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a double-buffered
// value. New values reach the display only at frame boundaries (index wrap to
// digit 0), so a frame never mixes old and new digits.
// Optional feature macro: SEG7_DECIMAL_POINT_EN (adds dp_in / dp).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BCD_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > MAX_DIGITS)) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be within 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seg7_scan_driver: REFRESH_DIV must be at least 2");
  end

  logic [PRE_W-1:0]      pre_cnt;
  logic                  tick;
  logic                  boundary;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [BCD_W-1:0]      shadow;
  logic [BCD_W-1:0]      active;
  logic [BCD_W-1:0]      active_next;
  logic                  pending;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [NUM_DIGITS-1:0] an_next;

  // Scan timing: tick on the last prescaler count, boundary when the index wraps.
  always_comb begin
    tick     = (pre_cnt == LAST_PRE);
    boundary = tick && (idx == LAST_IDX);
    idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  end

  // Value used for the digit shown on this edge. A load coinciding with the
  // boundary bypasses the shadow so it is visible on digit 0 immediately.
  always_comb begin
    active_next = active;
    if (boundary) begin
      if (bus.load) begin
        active_next = bus.bcd_in;
      end else if (pending) begin
        active_next = shadow;
      end
    end
  end

  // Select the nibble and one-hot-low anode pattern for the upcoming index.
  always_comb begin
    nibble  = '0;
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nibble     = active_next[4*i +: 4];
        an_next[i] = 1'b0;
      end
    end
  end

  seg7_decoder u_decoder (
    .bcd (nibble),
    .seg (seg_dec)
  );

  // Prescaler: counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Digit index: starts at the last digit so the first tick selects digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= LAST_IDX;
    end else if (tick) begin
      idx <= idx_next;
    end
  end

  // Shadow/active double buffer; the last load before a boundary wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      active <= active_next;
      if (bus.load) begin
        shadow  <= bus.bcd_in;
        pending <= !boundary;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs; blank darkens them but leaves scanning running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an         <= '1;
      bus.seg7       <= SEG_BLANK;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= boundary;
      if (bus.blank) begin
        bus.an   <= '1;
        bus.seg7 <= SEG_BLANK;
      end else if (tick) begin
        bus.an   <= an_next;
        bus.seg7 <= seg_dec;
      end
    end
  end

`ifdef SEG7_DECIMAL_POINT_EN
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [NUM_DIGITS-1:0] active_dp_next;
  logic                  dp_sel;

  // Decimal points follow exactly the same capture/swap rules as the digits.
  always_comb begin
    active_dp_next = active_dp;
    if (boundary) begin
      if (bus.load) begin
        active_dp_next = bus.dp_in;
      end else if (pending) begin
        active_dp_next = shadow_dp;
      end
    end
    dp_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        dp_sel = active_dp_next[i];
      end
    end
  end

  // Decimal-point buffers, updated alongside the digit buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dp <= '0;
      active_dp <= '0;
    end else begin
      active_dp <= active_dp_next;
      if (bus.load) begin
        shadow_dp <= bus.dp_in;
      end
    end
  end

  // Active-low decimal point output, dark while blanked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dp <= 1'b1;
    end else if (bus.blank) begin
      bus.dp <= 1'b1;
    end else if (tick) begin
      bus.dp <= ~dp_sel;
    end
  end
`endif

endmodule
